uart_rx_oversampled: RTL and testbench

Parametrised oversampling UART receiver: successor to the fixed 8-bit, even-parity, 8-clocks-per-bit receiver used in the loopback UART. Adds runtime baud divisor, configurable width, parity, stop bits and oversampling, majority-vote sampling, break detection, and a valid/ready output with overrun reporting. Sits between the pad-side `serial_in` and any word consumer, such as a FIFO or register bank.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_oversampled.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver FSM states and the
// parity helper used by both the receiver and the parametrised transmitter.
package uart_pkg;

    localparam logic [1:0] UART_PAR_NONE = 2'd0;
    localparam logic [1:0] UART_PAR_EVEN = 2'd1;
    localparam logic [1:0] UART_PAR_ODD  = 2'd2;

    localparam int UART_MAX_WIDTH = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } uart_rx_state_e;

    // Callers with narrower words zero-extend; the padding does not change the XOR.
    function automatic logic uart_parity_bit(input logic [UART_MAX_WIDTH-1:0] data,
                                             input logic [1:0]                mode);
        logic p;
        case (mode)
            UART_PAR_EVEN: p = ^data;
            UART_PAR_ODD:  p = ~^data;
            default:       p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: free-running down-counter that can be restarted,
// latching a fresh divisor so mid-frame baud_div changes are ignored.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 restart,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (restart) begin
            div_q <= baud_div;
            cnt_q <= baud_div;
        end else if (cnt_q == '0) begin
            cnt_q <= div_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // A restart cycle never counts as a tick, so the first tick of a frame
    // lands a full tick period after start detection.
    assign tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with majority-vote bit decisions, break detection
// and a single-word valid/ready output register with overrun reporting.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int SC_W       = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_WIDTH);
    localparam int SC_VOTE0   = OVERSAMPLE / 2 - 1;
    localparam int SC_VOTE1   = OVERSAMPLE / 2;
    localparam int SC_DECIDE  = OVERSAMPLE / 2 + 1;
    localparam int SC_LAST    = OVERSAMPLE - 1;
    localparam bit HAS_PARITY = (PARITY_MODE != 0);
    localparam logic [1:0] PAR_MODE = 2'(PARITY_MODE);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rx_s;
    logic                      tick;
    logic                      restart;
    logic                      complete;
    logic                      at_vote0;
    logic                      at_vote1;
    logic                      at_decide;
    logic                      at_wrap;
    logic                      vote;
    logic                      last_stop;
    logic                      frame_err_now;
    logic                      brk_now;
    logic                      parity_err_now;
    logic [UART_MAX_WIDTH-1:0] data_ext;

    uart_rx_state_e            state;
    uart_rx_state_e            state_next;
    logic [SC_W-1:0]           sc;
    logic [BIT_W-1:0]          bit_idx;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic                      v0_q;
    logic                      v1_q;
    logic                      par_bit_q;
    logic                      stop_idx_q;
    logic                      stop_zero_q;

    // The synchroniser powers up to the idle line level so reset is not a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk      (clk),
        .reset    (reset),
        .baud_div (baud_div),
        .restart  (restart),
        .tick     (tick)
    );

    assign at_vote0  = tick && (sc == SC_W'(SC_VOTE0));
    assign at_vote1  = tick && (sc == SC_W'(SC_VOTE1));
    assign at_decide = tick && (sc == SC_W'(SC_DECIDE));
    assign at_wrap   = tick && (sc == SC_W'(SC_LAST));
    assign vote      = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
    assign last_stop = (STOP_BITS == 1) || stop_idx_q;

    always_comb begin
        data_ext = '0;
        data_ext[DATA_WIDTH-1:0] = shift_q;
    end

    assign frame_err_now  = stop_zero_q | ~vote;
    assign brk_now        = (shift_q == '0) && (!HAS_PARITY || !par_bit_q) && frame_err_now;
    assign parity_err_now = HAS_PARITY && (par_bit_q != uart_parity_bit(data_ext, PAR_MODE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    restart    = 1'b1;
                end
            end
            ST_START: begin
                if (at_decide && vote) begin
                    state_next = ST_IDLE;
                end else if (at_wrap) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_wrap && (bit_idx == BIT_W'(DATA_WIDTH - 1))) begin
                    state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_wrap) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finishing at the decision point leaves half a bit to catch a back-to-back start.
                if (at_decide && last_stop) begin
                    complete   = 1'b1;
                    state_next = brk_now ? ST_BRK_WAIT : ST_IDLE;
                end
            end
            ST_BRK_WAIT: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sc          <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            v0_q        <= 1'b1;
            v1_q        <= 1'b1;
            par_bit_q   <= 1'b0;
            stop_idx_q  <= 1'b0;
            stop_zero_q <= 1'b0;
        end else if (restart) begin
            sc          <= '0;
            bit_idx     <= '0;
            stop_idx_q  <= 1'b0;
            stop_zero_q <= 1'b0;
        end else begin
            if (tick) begin
                sc <= at_wrap ? '0 : sc + 1'b1;
            end
            if (at_vote0) begin
                v0_q <= rx_s;
            end
            if (at_vote1) begin
                v1_q <= rx_s;
            end
            if (state == ST_DATA && at_decide) begin
                shift_q <= {vote, shift_q[DATA_WIDTH-1:1]};
            end
            if (state == ST_DATA && at_wrap) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == ST_PARITY && at_decide) begin
                par_bit_q <= vote;
            end
            if (state == ST_STOP && at_decide && !vote) begin
                stop_zero_q <= 1'b1;
            end
            if (state == ST_STOP && at_wrap) begin
                stop_idx_q <= 1'b1;
            end
        end
    end

    // A completion is accepted only when the held word is free or leaving this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (complete && (!o_valid || i_ready)) begin
            o_data       <= brk_now ? '0 : shift_q;
            o_valid      <= 1'b1;
            o_parity_err <= parity_err_now;
            o_frame_err  <= frame_err_now;
            o_break      <= brk_now;
            o_overrun    <= 1'b0;
        end else if (complete) begin
            o_overrun    <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_busy <= 1'b0;
        end else begin
            o_busy <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: three instances cover even parity,
// odd parity and two stop bits; expected values are hand-computed per frame.
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic [2:0]  ser;
    logic [2:0]  rdy;
    logic [2:0]  valid;
    logic [2:0]  perr;
    logic [2:0]  ferr;
    logic [2:0]  brk;
    logic [2:0]  ovr;
    logic [2:0]  busy;
    logic [7:0]  dout [3];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        seen_valid;

    always #5 clk = ~clk;

    uart_rx_oversampled #(.PARITY_MODE(1), .STOP_BITS(1)) dut_even (
        .clk(clk), .reset(reset), .baud_div(baud_div), .serial_in(ser[0]),
        .o_data(dout[0]), .o_valid(valid[0]), .i_ready(rdy[0]),
        .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_break(brk[0]),
        .o_overrun(ovr[0]), .o_busy(busy[0])
    );

    uart_rx_oversampled #(.PARITY_MODE(2), .STOP_BITS(1)) dut_odd (
        .clk(clk), .reset(reset), .baud_div(baud_div), .serial_in(ser[1]),
        .o_data(dout[1]), .o_valid(valid[1]), .i_ready(rdy[1]),
        .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_break(brk[1]),
        .o_overrun(ovr[1]), .o_busy(busy[1])
    );

    uart_rx_oversampled #(.PARITY_MODE(1), .STOP_BITS(2)) dut_two_stop (
        .clk(clk), .reset(reset), .baud_div(baud_div), .serial_in(ser[2]),
        .o_data(dout[2]), .o_valid(valid[2]), .i_ready(rdy[2]),
        .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_break(brk[2]),
        .o_overrun(ovr[2]), .o_busy(busy[2])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_bit(input int which, input logic b);
        ser[which] = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Start bit, eight data bits LSB first, parity bit; ends on the stop-bit boundary.
    task automatic apply_head(input int which, input logic [7:0] data, input logic par);
        apply_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply_bit(which, data[i]);
        end
        apply_bit(which, par);
    endtask

    task automatic apply_frame(input int which, input logic [7:0] data, input logic par,
                               input logic stop1, input logic stop2, input int nstop);
        apply_head(which, data, par);
        apply_bit(which, stop1);
        if (nstop == 2) begin
            apply_bit(which, stop2);
        end
        ser[which] = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic apply_handshake(input int which);
        rdy[which] = 1'b1;
        @(negedge clk);
        rdy[which] = 1'b0;
    endtask

    task automatic wait_valid(input int which, input string tag);
        int n = 0;
        while (!valid[which] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, valid[which], 1'b1);
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset    = 1'b1;
        baud_div = 16'd4;
        ser      = 3'b111;
        rdy      = 3'b000;
        repeat (4) @(negedge clk);
        check_output("reset_data",  dout[0], 8'h00);
        check_output("reset_valid", valid[0], 1'b0);
        check_output("reset_flags", {perr[0], ferr[0], brk[0], ovr[0]}, 4'b0000);
        check_output("reset_busy",  busy[0], 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 0xA5 even parity: valid must rise exactly one clock after the stop decision tick.
        apply_head(0, 8'hA5, 1'b0);
        ser[0] = 1'b1;
        repeat (53) @(negedge clk);
        check_output("a5_valid_early", valid[0], 1'b0);
        @(negedge clk);
        check_output("a5_valid_rise", valid[0], 1'b1);
        check_output("a5_data", dout[0], 8'hA5);
        check_output("a5_flags", {perr[0], ferr[0], brk[0], ovr[0]}, 4'b0000);
        repeat (26) @(negedge clk);
        apply_handshake(0);
        check_output("a5_valid_clear", valid[0], 1'b0);

        apply_frame(1, 8'h3C, 1'b0, 1'b1, 1'b1, 1);
        wait_valid(1, "odd_valid");
        check_output("odd_data", dout[1], 8'h3C);
        check_output("odd_parity_err", perr[1], 1'b1);
        check_output("odd_frame_err", ferr[1], 1'b0);
        apply_handshake(1);
        check_output("odd_valid_clear", valid[1], 1'b0);

        // Three-clock glitch: start is detected, then rejected by the vote.
        ser[0] = 1'b0;
        repeat (3) @(negedge clk);
        ser[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_output("glitch_busy_high", busy[0], 1'b1);
        seen_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | valid[0];
        end
        check_output("glitch_no_valid", seen_valid, 1'b0);
        check_output("glitch_busy_low", busy[0], 1'b0);

        apply_frame(2, 8'h96, 1'b0, 1'b1, 1'b0, 2);
        wait_valid(2, "frame_valid");
        check_output("frame_data", dout[2], 8'h96);
        check_output("frame_err", ferr[2], 1'b1);
        check_output("frame_break", brk[2], 1'b0);
        apply_handshake(2);
        repeat (100) @(negedge clk);

        ser[2] = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check_output("break_valid", valid[2], 1'b1);
        check_output("break_flag", brk[2], 1'b1);
        check_output("break_frame_err", ferr[2], 1'b1);
        check_output("break_data", dout[2], 8'h00);
        check_output("break_wait_busy", busy[2], 1'b1);
        ser[2] = 1'b1;
        repeat (10) @(negedge clk);
        check_output("break_release_busy", busy[2], 1'b0);
        apply_handshake(2);

        apply_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 1);
        apply_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 1);
        check_output("ovr_valid", valid[0], 1'b1);
        check_output("ovr_data", dout[0], 8'h11);
        check_output("ovr_flag", ovr[0], 1'b1);
        apply_handshake(0);
        check_output("ovr_valid_clear", valid[0], 1'b0);
        check_output("ovr_flag_clear", ovr[0], 1'b0);

        // 0x44 completes in the same cycle that 0x33 is accepted.
        apply_frame(0, 8'h33, 1'b0, 1'b1, 1'b1, 1);
        apply_head(0, 8'h44, 1'b0);
        ser[0] = 1'b1;
        repeat (53) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        check_output("simul_valid", valid[0], 1'b1);
        check_output("simul_data", dout[0], 8'h44);
        check_output("simul_overrun", ovr[0], 1'b0);
        repeat (26) @(negedge clk);
        apply_handshake(0);

        // Abort a frame during data bit 3 with reset.
        apply_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_bit(0, 1'b1);
        end
        ser[0] = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        ser[0] = 1'b1;
        repeat (100) @(negedge clk);
        check_output("abort_no_valid", valid[0], 1'b0);
        check_output("abort_busy", busy[0], 1'b0);

        // Clean 0x5A with baud_div moved to 9 mid-frame; line timing stays at divisor 4.
        apply_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                baud_div = 16'd9;
            end
            apply_bit(0, 8'h5A >> i);
        end
        apply_bit(0, 1'b0);
        apply_bit(0, 1'b1);
        ser[0] = 1'b1;
        repeat (20) @(negedge clk);
        wait_valid(0, "resync_valid");
        check_output("resync_data", dout[0], 8'h5A);
        check_output("resync_flags", {perr[0], ferr[0], brk[0], ovr[0]}, 4'b0000);
        baud_div = 16'd4;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
